muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide execution unit, parametrised in width. Sits beside the ALU in the

---
 rtl/muldiv_unit.sv | 259 +++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RV32M multiply/divide unit that sits beside the ALU. It takes one
// operation at a time. Multiplies use a shift-add product register. Divides use
// restoring division. Either one needs DATA_WIDTH CALC cycles, then one FIXUP
// cycle that applies the result sign and selects the output word. When
// EARLY_OUT is set, division by zero and signed overflow skip CALC and go
// straight to DONE.
//
// Ports
//   i_clk      clock, rising edge
//   i_reset    synchronous, active-high reset
//   i_valid    request valid (accepted when o_ready is high and no flush)
//   o_ready    unit idle and able to accept a request
//   i_funct3   RV32M op select: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   i_rs1      operand A (multiplicand / dividend)
//   i_rs2      operand B (multiplier / divisor)
//   i_flush    abort any in-flight operation and discard its result
//   o_valid    result valid, held until i_ready
//   i_ready    consumer accepts the result
//   o_result   result word
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNCT3_WIDTH = 3,
    parameter int EARLY_OUT    = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [FUNCT3_WIDTH-1:0] i_funct3,
    input  logic [DATA_WIDTH-1:0]   i_rs1,
    input  logic [DATA_WIDTH-1:0]   i_rs2,
    input  logic                    i_flush,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [DATA_WIDTH-1:0]   o_result
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [FUNCT3_WIDTH-1:0] F3_MUL    = FUNCT3_WIDTH'(0);
    localparam logic [FUNCT3_WIDTH-1:0] F3_MULH   = FUNCT3_WIDTH'(1);
    localparam logic [FUNCT3_WIDTH-1:0] F3_MULHSU = FUNCT3_WIDTH'(2);
    localparam logic [FUNCT3_WIDTH-1:0] F3_MULHU  = FUNCT3_WIDTH'(3);
    localparam logic [FUNCT3_WIDTH-1:0] F3_DIV    = FUNCT3_WIDTH'(4);
    localparam logic [FUNCT3_WIDTH-1:0] F3_DIVU   = FUNCT3_WIDTH'(5);
    localparam logic [FUNCT3_WIDTH-1:0] F3_REM    = FUNCT3_WIDTH'(6);
    localparam logic [FUNCT3_WIDTH-1:0] F3_REMU   = FUNCT3_WIDTH'(7);

    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] MIN_INT  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic is_div_op(input logic [FUNCT3_WIDTH-1:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    state_t                    state_q, state_d;
    logic [FUNCT3_WIDTH-1:0]   op_q, op_d;
    logic [DATA_WIDTH-1:0]     mcand_q, mcand_d;    // multiplicand or divisor magnitude
    logic [2*DATA_WIDTH-1:0]   prod_q, prod_d;      // mul: {acc, multiplier}; div: {remainder, dividend/quotient}
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      neg_q, neg_d;        // negate product / quotient in FIXUP
    logic                      neg_rem_q, neg_rem_d; // negate remainder in FIXUP
    logic [DATA_WIDTH-1:0]     result_q, result_d;

    // ---------------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------------
    logic                  accept;
    logic                  req_is_div;
    logic                  a_signed, b_signed;
    logic                  a_neg, b_neg;
    logic [DATA_WIDTH-1:0] a_mag, b_mag;
    logic                  div_by_zero, signed_ovf, take_early;
    logic [DATA_WIDTH-1:0] early_result;

    assign accept     = (state_q == IDLE) && i_valid && !i_flush;
    assign req_is_div = is_div_op(i_funct3);

    assign a_signed = (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU) ||
                      (i_funct3 == F3_DIV)  || (i_funct3 == F3_REM);
    assign b_signed = (i_funct3 == F3_MULH) || (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);

    assign a_neg = a_signed && i_rs1[DATA_WIDTH-1];
    assign b_neg = b_signed && i_rs2[DATA_WIDTH-1];
    assign a_mag = a_neg ? -i_rs1 : i_rs1;
    assign b_mag = b_neg ? -i_rs2 : i_rs2;

    assign div_by_zero = req_is_div && (i_rs2 == '0);
    assign signed_ovf  = ((i_funct3 == F3_DIV) || (i_funct3 == F3_REM)) &&
                         (i_rs1 == MIN_INT) && (i_rs2 == ALL_ONES);
    assign take_early  = (EARLY_OUT != 0) && (div_by_zero || signed_ovf);

    always_comb begin
        early_result = '0;
        if (div_by_zero) begin
            early_result = ((i_funct3 == F3_DIV) || (i_funct3 == F3_DIVU)) ? ALL_ONES : i_rs1;
        end else if (signed_ovf) begin
            early_result = (i_funct3 == F3_DIV) ? MIN_INT : '0;
        end
    end

    // ---------------------------------------------------------------------
    // One iteration step
    // ---------------------------------------------------------------------
    logic                  op_is_div;
    logic [DATA_WIDTH:0]   mul_sum;
    logic [2*DATA_WIDTH-1:0] mul_step;
    logic [DATA_WIDTH:0]   div_shifted, div_diff;
    logic                  q_bit;
    logic [2*DATA_WIDTH-1:0] div_step;

    assign op_is_div = is_div_op(op_q);

    // Add the multiplicand when the multiplier LSB is set; the carry is kept
    // and shifted into the product's top bit.
    assign mul_sum  = {1'b0, prod_q[2*DATA_WIDTH-1:DATA_WIDTH]} +
                      (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_step = {mul_sum, prod_q[DATA_WIDTH-1:1]};

    // Shift the next dividend bit into the remainder, then trial-subtract.
    // Bit DATA_WIDTH of the difference is the borrow: clear means it fits.
    assign div_shifted = prod_q[2*DATA_WIDTH-1:DATA_WIDTH-1];
    assign div_diff    = div_shifted - {1'b0, mcand_q};
    assign q_bit       = ~div_diff[DATA_WIDTH];
    assign div_step    = {(q_bit ? div_diff[DATA_WIDTH-1:0] : div_shifted[DATA_WIDTH-1:0]),
                          prod_q[DATA_WIDTH-2:0], q_bit};

    // ---------------------------------------------------------------------
    // Sign fixup and output select
    // ---------------------------------------------------------------------
    logic [2*DATA_WIDTH-1:0] prod_fixed;
    logic [DATA_WIDTH-1:0]   quot_fixed, rem_fixed, fixup_result;

    assign prod_fixed = neg_q     ? -prod_q : prod_q;
    assign quot_fixed = neg_q     ? -prod_q[DATA_WIDTH-1:0] : prod_q[DATA_WIDTH-1:0];
    assign rem_fixed  = neg_rem_q ? -prod_q[2*DATA_WIDTH-1:DATA_WIDTH]
                                  :  prod_q[2*DATA_WIDTH-1:DATA_WIDTH];

    always_comb begin
        fixup_result = rem_fixed;
        if (op_q == F3_MUL) begin
            fixup_result = prod_fixed[DATA_WIDTH-1:0];
        end else if ((op_q == F3_MULH) || (op_q == F3_MULHSU) || (op_q == F3_MULHU)) begin
            fixup_result = prod_fixed[2*DATA_WIDTH-1:DATA_WIDTH];
        end else if ((op_q == F3_DIV) || (op_q == F3_DIVU)) begin
            fixup_result = quot_fixed;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = take_early ? DONE : CALC;
            CALC:    if (cnt_q == CNT_W'(DATA_WIDTH-1)) state_d = FIXUP;
            FIXUP:   state_d = DONE;
            DONE:    if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Flush wins over everything, including a same-cycle request or i_ready.
        if (i_flush) state_d = IDLE;
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        o_ready  = (state_q == IDLE);
        o_valid  = (state_q == DONE);
        o_result = result_q;
    end

    // ---------------------------------------------------------------------
    // Datapath next state
    // ---------------------------------------------------------------------
    always_comb begin
        op_d      = op_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = i_funct3;
                    cnt_d   = '0;
                    mcand_d = req_is_div ? b_mag : a_mag;
                    prod_d  = {{DATA_WIDTH{1'b0}}, (req_is_div ? a_mag : b_mag)};
                    // x/0 must give an all-ones quotient, so its sign is forced positive.
                    neg_d     = (a_neg ^ b_neg) && !div_by_zero;
                    neg_rem_d = a_neg;
                    if (take_early) result_d = early_result;
                end
            end
            CALC: begin
                cnt_d  = cnt_q + CNT_W'(1);
                prod_d = op_is_div ? div_step : mul_step;
            end
            FIXUP: begin
                result_d = fixup_result;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            op_q      <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            op_q      <= op_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Self-checking bench for muldiv_unit (DATA_WIDTH=32, EARLY_OUT=1). It compares
// results against an arithmetic reference of the RV32M rules and checks
// latency, backpressure, flush and reset behaviour.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_muldiv_unit;

    localparam int W         = 32;
    localparam int LAT_BOUND = 100;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [W-1:0] MIN_INT  = 32'h8000_0000;
    localparam logic [W-1:0] ALL_ONES = 32'hFFFF_FFFF;

    logic         clk;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic [2:0]   i_funct3;
    logic [W-1:0] i_rs1;
    logic [W-1:0] i_rs2;
    logic         i_flush;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(
        .DATA_WIDTH  (W),
        .FUNCT3_WIDTH(3),
        .EARLY_OUT   (1)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_funct3(i_funct3),
        .i_rs1   (i_rs1),
        .i_rs2   (i_rs2),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_result(o_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Reference model: RV32M semantics in plain arithmetic
    // ---------------------------------------------------------------------
    function automatic logic [W-1:0] ref_result(input logic [2:0] f3,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [2*W-1:0] sa, sb, ua, ub, p;
        int ia, ib;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        ua = {{W{1'b0}}, a};
        ub = {{W{1'b0}}, b};
        ia = a;
        ib = b;
        p  = '0;
        case (f3)
            OP_MUL:    begin p = ua * ub; return p[W-1:0];   end
            OP_MULH:   begin p = sa * sb; return p[2*W-1:W]; end
            OP_MULHSU: begin p = sa * ub; return p[2*W-1:W]; end
            OP_MULHU:  begin p = ua * ub; return p[2*W-1:W]; end
            OP_DIV: begin
                if (b == 0) return ALL_ONES;
                if (a == MIN_INT && b == ALL_ONES) return MIN_INT;
                return ia / ib;
            end
            OP_DIVU: begin
                if (b == 0) return ALL_ONES;
                return a / b;
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == MIN_INT && b == ALL_ONES) return '0;
                return ia % ib;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3,
                                       input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        bit special;
        special = (f3 >= OP_DIV && b == 0) ||
                  ((f3 == OP_DIV || f3 == OP_REM) && a == MIN_INT && b == ALL_ONES);
        return special ? 1 : W + 2;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return MIN_INT;
            2:       return ALL_ONES;
            3:       return W'($urandom_range(0, 15));
            4:       return 32'd1;
            default: return W'($urandom);
        endcase
    endfunction

    // ---------------------------------------------------------------------
    // Handshake helpers
    // ---------------------------------------------------------------------
    // Present a request in one cycle; the following rising edge is the accept edge.
    task automatic start_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        i_valid  = 1'b1;
        i_funct3 = f3;
        i_rs1    = a;
        i_rs2    = b;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready: o_ready=%b, required 1", o_ready);
        end
        @(posedge clk);
        #1;
        i_valid  = 1'b0;
        i_funct3 = 3'($urandom);
        i_rs1    = W'($urandom);
        i_rs2    = W'($urandom);
    endtask

    // Count cycles after the accept edge until o_valid is seen (cycle 1 is the first).
    task automatic wait_result(output logic [W-1:0] res, output int lat);
        lat = 0;
        res = '0;
        for (int c = 1; c <= LAT_BOUND; c++) begin
            @(negedge clk);
            if (o_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: o_valid not seen within %0d cycles", LAT_BOUND);
        end else begin
            res = o_result;
        end
    endtask

    task automatic accept_result();
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_valid_drop: o_valid=%b, required 0", o_valid);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_idle: o_ready=%b, required 1", o_ready);
        end
    endtask

    // Full operation with result, latency, backpressure and return-to-idle checks.
    task automatic do_op(input string name, input logic [2:0] f3,
                         input logic [W-1:0] a, input logic [W-1:0] b, input int bp);
        logic [W-1:0] res, exp;
        int lat, exp_lat;
        exp     = ref_result(f3, a, b);
        exp_lat = ref_latency(f3, a, b);
        start_op(f3, a, b);
        wait_result(res, lat);
        if (lat != 0) begin
            checks++;
            if (res !== exp) begin
                errors++;
                $display("FAIL %s result: op=%0d a=%h b=%h got %h, required %h", name, f3, a, b, res, exp);
            end
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, exp_lat);
            end
            checks++;
            if (o_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s done_ready: o_ready=%b, required 0", name, o_ready);
            end
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                checks++;
                if (o_valid !== 1'b1 || o_result !== exp) begin
                    errors++;
                    $display("FAIL %s hold: o_valid=%b o_result=%h, required 1 and %h", name, o_valid, o_result, exp);
                end
            end
        end
        accept_result();
    endtask

    // Watch n cycles and report if o_valid ever rises.
    task automatic expect_no_valid(input string name, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL %s: o_valid rose, required to stay 0", name);
        end
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b result=%h, required 1 0 00000000",
                     o_ready, o_valid, o_result);
        end
    endtask

    task automatic test_directed();
        do_op("mul_neg3",      OP_MUL,    32'd7,        32'hFFFF_FFFD, 0);
        do_op("mulhu_neg3",    OP_MULHU,  32'd7,        32'hFFFF_FFFD, 0);
        do_op("mulh_min",      OP_MULH,   MIN_INT,      MIN_INT,       0);
        do_op("mulhsu_ones",   OP_MULHSU, ALL_ONES,     ALL_ONES,      0);
        do_op("div_neg7",      OP_DIV,    32'hFFFF_FFF9, 32'd2,        0);
        do_op("rem_neg7",      OP_REM,    32'hFFFF_FFF9, 32'd2,        0);
        do_op("divu_100_7",    OP_DIVU,   32'd100,      32'd7,         0);
        do_op("remu_100_7",    OP_REMU,   32'd100,      32'd7,         0);
        do_op("divu_by_zero",  OP_DIVU,   32'd5,        32'd0,         0);
        do_op("rem_by_zero",   OP_REM,    32'd5,        32'd0,         0);
        do_op("div_neg_by_0",  OP_DIV,    32'hFFFF_FFF0, 32'd0,        0);
        do_op("div_overflow",  OP_DIV,    MIN_INT,      ALL_ONES,      0);
        do_op("rem_overflow",  OP_REM,    MIN_INT,      ALL_ONES,      0);
        do_op("rem_neg_div",   OP_REM,    32'd7,        32'hFFFF_FFFE, 0);
    endtask

    task automatic test_backpressure();
        do_op("bp_mul", OP_MULH, 32'h1234_5678, 32'hFEDC_BA98, 5);
        do_op("bp_div", OP_DIV,  32'd5,         32'd0,         5);
    endtask

    task automatic test_flush();
        // Flush in cycle 10 of a multiply.
        start_op(OP_MUL, 32'h0000_1234, 32'h0000_5678);
        repeat (10) @(negedge clk);
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc_idle: ready=%b valid=%b, required 1 0", o_ready, o_valid);
        end
        expect_no_valid("flush_calc_no_valid", 40);
        do_op("after_flush", OP_MUL, 32'h0000_1234, 32'h0000_5678, 0);

        // Flush together with a request: the request is dropped.
        @(negedge clk);
        i_valid  = 1'b1;
        i_flush  = 1'b1;
        i_funct3 = OP_DIVU;
        i_rs1    = 32'd9;
        i_rs2    = 32'd0;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_with_valid: o_ready=%b, required 1", o_ready);
        end
        expect_no_valid("flush_with_valid_no_valid", 40);

        // Flush in DONE discards the result even without i_ready.
        begin
            logic [W-1:0] res;
            int lat;
            start_op(OP_DIVU, 32'd50, 32'd0);
            wait_result(res, lat);
            i_flush = 1'b1;
            @(posedge clk);
            #1;
            i_flush = 1'b0;
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
                errors++;
                $display("FAIL flush_done: valid=%b ready=%b, required 0 1", o_valid, o_ready);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        start_op(OP_DIV, 32'h7654_3210, 32'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_result !== '0) begin
            errors++;
            $display("FAIL reset_mid_op: ready=%b result=%h, required 1 00000000", o_ready, o_result);
        end
        expect_no_valid("reset_mid_op_no_valid", 40);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] res, exp2;
        int lat;
        do_op("b2b_first", OP_MUL, 32'd3, 32'd5, 0);
        // Result accept and a new request in the same cycle: request must wait.
        start_op(OP_REMU, 32'd1000, 32'd33);
        wait_result(res, lat);
        i_ready  = 1'b1;
        i_valid  = 1'b1;
        i_funct3 = OP_DIVU;
        i_rs1    = 32'd1000;
        i_rs2    = 32'd33;
        exp2     = ref_result(OP_DIVU, 32'd1000, 32'd33);
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_not_taken_in_done: ready=%b valid=%b, required 1 0", o_ready, o_valid);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        wait_result(res, lat);
        if (lat != 0) begin
            checks++;
            if (res !== exp2 || lat != W + 2) begin
                errors++;
                $display("FAIL b2b_second: got %h after %0d cycles, required %h after %0d",
                         res, lat, exp2, W + 2);
            end
        end
        accept_result();
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            logic [2:0]   f3;
            logic [W-1:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            do_op("random", f3, a, b, $urandom_range(0, 2));
        end
    endtask

    initial begin
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_funct3 = '0;
        i_rs1    = '0;
        i_rs2    = '0;
        i_flush  = 1'b0;
        i_ready  = 1'b0;

        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_mid_op();
        test_back_to_back();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
